ifetch_req: RTL and testbench

IFETCH_REQ -- requirements
Module: ifetch_req

---
 rtl/ifetch_req.sv | 175 +++++++++++++++++
 tb/tb_ifetch_req.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_req.sv
// ifetch_req: sequential instruction fetch front-end feeding a small in-order fetch queue.
// Optional performance counters are compiled in when IFETCH_PERF_EN is defined.
module ifetch_req #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}},
    parameter int unsigned     FQ_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] mem_raddr,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_wr_busy,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_redirect_cnt
`endif
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_W = FQ_DEPTH[CNT_W:0];
    localparam logic [XLEN-1:0]   PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0]  pc_r;
    logic             inflight_r;
    logic [XLEN-1:0]  inflight_pc_r;
    logic [XLEN-1:0]  q_pc_r   [FQ_DEPTH];
    logic [XLEN-1:0]  q_inst_r [FQ_DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             out_valid_r;
    logic [XLEN-1:0]  out_pc_r;
    logic [XLEN-1:0]  out_inst_r;

    logic             pop_s;
    logic             push_s;
    logic             issue_s;
    logic [CNT_W:0]   demand_s;
    logic [PTR_W-1:0] head_n_s;
    logic [PTR_W-1:0] tail_n_s;
    logic [CNT_W-1:0] count_n_s;
    logic [XLEN-1:0]  head_pc_n_s;
    logic [XLEN-1:0]  head_inst_n_s;
    logic             unused_s;

    assign unused_s = ^redirect_pc[1:0];

    // Handshake decode and issue gating; a pop this cycle frees a slot for the next read.
    always_comb begin
        pop_s    = out_valid_r & out_ready;
        push_s   = inflight_r & ~redirect_valid;
        demand_s = {1'b0, count_r} - (CNT_W+1)'(pop_s) + (CNT_W+1)'(inflight_r);
        issue_s  = ~mem_wr_busy & ~redirect_valid & (demand_s < DEPTH_W);
    end

    // Next queue pointers and occupancy; a redirect empties the queue.
    always_comb begin
        head_n_s  = head_r;
        tail_n_s  = tail_r;
        count_n_s = count_r;
        if (redirect_valid) begin
            head_n_s  = {PTR_W{1'b0}};
            tail_n_s  = {PTR_W{1'b0}};
            count_n_s = {CNT_W{1'b0}};
        end else begin
            head_n_s  = head_r + PTR_W'(pop_s);
            tail_n_s  = tail_r + PTR_W'(push_s);
            count_n_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Next head entry, bypassing the word being written when it lands in an empty slot.
    always_comb begin
        head_pc_n_s   = {XLEN{1'b0}};
        head_inst_n_s = {XLEN{1'b0}};
        if (count_n_s == {CNT_W{1'b0}}) begin
            head_pc_n_s   = {XLEN{1'b0}};
            head_inst_n_s = {XLEN{1'b0}};
        end else if (push_s && (tail_r == head_n_s)) begin
            head_pc_n_s   = inflight_pc_r;
            head_inst_n_s = mem_rdata;
        end else begin
            head_pc_n_s   = q_pc_r[head_n_s];
            head_inst_n_s = q_inst_r[head_n_s];
        end
    end

    // Fetch pc, in-flight tracking and queue pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= {XLEN{1'b0}};
            head_r        <= {PTR_W{1'b0}};
            tail_r        <= {PTR_W{1'b0}};
            count_r       <= {CNT_W{1'b0}};
        end else begin
            if (redirect_valid) begin
                pc_r <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (issue_s) begin
                pc_r <= pc_r + PC_STEP;
            end
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= pc_r;
            end
            head_r  <= head_n_s;
            tail_r  <= tail_n_s;
            count_r <= count_n_s;
        end
    end

    // Queue storage; mem_rdata is only captured in the cycle after an issue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                q_pc_r[i]   <= {XLEN{1'b0}};
                q_inst_r[i] <= {XLEN{1'b0}};
            end
        end else if (push_s) begin
            q_pc_r[tail_r]   <= inflight_pc_r;
            q_inst_r[tail_r] <= mem_rdata;
        end
    end

    // Registered consumer-side outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_pc_r    <= {XLEN{1'b0}};
            out_inst_r  <= {XLEN{1'b0}};
        end else begin
            out_valid_r <= (count_n_s != {CNT_W{1'b0}});
            out_pc_r    <= head_pc_n_s;
            out_inst_r  <= head_inst_n_s;
        end
    end

    assign mem_raddr = pc_r;
    assign out_valid = out_valid_r;
    assign out_pc    = out_pc_r;
    assign out_inst  = out_inst_r;

`ifdef IFETCH_PERF_EN
    logic [31:0] stall_cnt_r;
    logic [31:0] redirect_cnt_r;

    // Consumer back-pressure and redirect event counters, free-running with wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_r    <= 32'd0;
            redirect_cnt_r <= 32'd0;
        end else begin
            if (out_valid_r && !out_ready) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            if (redirect_valid) begin
                redirect_cnt_r <= redirect_cnt_r + 32'd1;
            end
        end
    end

    assign perf_stall_cnt    = stall_cnt_r;
    assign perf_redirect_cnt = redirect_cnt_r;
`endif

endmodule

// File: tb/tb_ifetch_req.sv
// Directed bench for ifetch_req: a word-memory model, and a scoreboard of expected pcs
// popped on every consumer transfer. Perf counters are checked when IFETCH_PERF_EN is set.
module tb_ifetch_req;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, reset1;
    logic [31:0] mem_raddr, mem_rdata, redirect_pc, out_pc, out_inst;
    logic        mem_wr_busy, redirect_valid, out_valid, out_ready;
    logic [31:0] mem_raddr1, mem_rdata1, out_pc1, out_inst1;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = 32'd0;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_stall_cnt, perf_redirect_cnt, perf_stall_cnt1, perf_redirect_cnt1;
`endif

    int checks = 0;
    int errors = 0;
    int xfers = 0;
    int xfers1 = 0;
    int stall_model = 0;
    int redirect_model = 0;
    logic [31:0] sb[$];
    logic [31:0] sb1[$];
    logic [31:0] mon_pc, mon_pc1;

    ifetch_req #(.XLEN(32), .RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
        .clock(clock), .reset(reset), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_wr_busy(mem_wr_busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
`ifdef IFETCH_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    ifetch_req #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(2)) dut1 (
        .clock(clock), .reset(reset1), .mem_raddr(mem_raddr1), .mem_rdata(mem_rdata1),
        .mem_wr_busy(zero1), .redirect_valid(zero1), .redirect_pc(zero32),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_pc(out_pc1), .out_inst(out_inst1)
`ifdef IFETCH_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt1), .perf_redirect_cnt(perf_redirect_cnt1)
`endif
    );

    function automatic logic [31:0] word_at(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
    endtask

    // Word memories: registered read data, no read while the write port is busy.
    always @(posedge clock) begin
        if (!mem_wr_busy) mem_rdata <= word_at(mem_raddr);
        mem_rdata1 <= word_at(mem_raddr1);
    end

    // Consumer-side scoreboard for dut.
    always @(negedge clock) begin
        if (reset && out_valid && !out_ready) stall_model++;
        if (reset && out_valid && out_ready) begin
            xfers++;
            check("xfer_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                mon_pc = sb.pop_front();
                check("xfer_pc", out_pc, mon_pc);
                check("xfer_inst", out_inst, word_at(mon_pc));
            end
        end
    end

    // Consumer-side scoreboard for dut1.
    always @(negedge clock) begin
        if (reset1 && out_valid1) begin
            xfers1++;
            check("xfer1_expected", {31'd0, sb1.size() != 0}, 32'd1);
            if (sb1.size() != 0) begin
                mon_pc1 = sb1.pop_front();
                check("xfer1_pc", out_pc1, mon_pc1);
                check("xfer1_inst", out_inst1, word_at(mon_pc1));
            end
        end
    end

    initial begin
        int b;
        int bubbles;
        int first_bubble;
        logic [31:0] stall_pc;

        reset = 1'b0; reset1 = 1'b0; out_ready = 1'b0;
        mem_wr_busy = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        repeat (3) tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_inst", out_inst, 32'd0);
        check("rst_raddr", mem_raddr, 32'd0);
        check("rst_raddr1", mem_raddr1, 32'hFFFF_FFF8);

        // Reset release with a ready consumer: first valid in cycle 2, then one per cycle.
        push_seq(32'd0, 64);
        reset = 1'b1; out_ready = 1'b1;
        check("c0_valid", {31'd0, out_valid}, 32'd0);
        check("c0_raddr", mem_raddr, 32'd0);
        tick();
        check("c1_valid", {31'd0, out_valid}, 32'd0);
        check("c1_raddr", mem_raddr, 32'd4);
        tick();
        check("c2_valid", {31'd0, out_valid}, 32'd1);
        check("c2_pc", out_pc, 32'd0);
        check("c2_inst", out_inst, 32'h1000_0000);
        b = xfers;
        repeat (20) tick();
        check("stream_rate", 32'(xfers - b), 32'd20);

        // Consumer stall: head stable, fetch address held.
        out_ready = 1'b0;
        stall_pc = 32'(4 * xfers);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_pc", out_pc, stall_pc);
            check("stall_inst", out_inst, word_at(stall_pc));
            check("stall_raddr", mem_raddr, stall_pc + 32'd8);
            tick();
        end
        // Drain with issue blocked: exactly the queue depth comes out.
        out_ready = 1'b1; mem_wr_busy = 1'b1;
        b = xfers;
        repeat (4) tick();
        check("full_depth", 32'(xfers - b), 32'd2);
        check("busy_raddr", mem_raddr, stall_pc + 32'd8);
        mem_wr_busy = 1'b0;
        repeat (10) tick();

        // Three busy cycles during streaming give a three-cycle bubble.
        bubbles = 0; first_bubble = -1;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid) begin
                bubbles++;
                if (first_bubble < 0) first_bubble = i;
            end
            mem_wr_busy = (i < 3);
            tick();
        end
        mem_wr_busy = 1'b0;
        check("busy_bubbles", 32'(bubbles), 32'd3);
        check("busy_first_bubble", 32'(first_bubble), 32'd2);
        repeat (4) tick();

        // Redirect while streaming with a read in flight and a same-cycle transfer.
        check("pre_redirect_valid", {31'd0, out_valid}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; redirect_model++;
        tick();
        redirect_valid = 1'b0;
        sb.delete();
        push_seq(32'h0000_0100, 40);
        check("redir1_r1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("redir1_r2_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("redir1_r3_valid", {31'd0, out_valid}, 32'd1);
        check("redir1_pc", out_pc, 32'h0000_0100);
        repeat (6) tick();

        // Redirect with the queue full.
        out_ready = 1'b0;
        repeat (4) tick();
        check("full_before_redirect", {31'd0, out_valid}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; redirect_model++;
        tick();
        redirect_valid = 1'b0;
        sb.delete();
        push_seq(32'h0000_0200, 40);
        check("redir2_r1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("redir2_r2_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("redir2_r3_valid", {31'd0, out_valid}, 32'd1);
        check("redir2_pc", out_pc, 32'h0000_0200);
        out_ready = 1'b1;
        repeat (8) tick();

        // Asynchronous reset with the queue full.
        out_ready = 1'b0;
        repeat (4) tick();
`ifdef IFETCH_PERF_EN
        check("perf_redirect", perf_redirect_cnt, 32'(redirect_model));
        check("perf_stall", perf_stall_cnt, 32'(stall_model));
`endif
        check("full_before_reset", {31'd0, out_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_pc", out_pc, 32'd0);
        check("async_rst_inst", out_inst, 32'd0);
        check("async_rst_raddr", mem_raddr, 32'd0);
`ifdef IFETCH_PERF_EN
        check("perf_rst_redirect", perf_redirect_cnt, 32'd0);
        check("perf_rst_stall", perf_stall_cnt, 32'd0);
`endif
        sb.delete();
        stall_model = 0;
        tick();
        push_seq(32'd0, 20);
        reset = 1'b1; out_ready = 1'b1;
        check("rr_c0_raddr", mem_raddr, 32'd0);
        tick();
        check("rr_c1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("rr_c2_valid", {31'd0, out_valid}, 32'd1);
        check("rr_c2_pc", out_pc, 32'd0);
        repeat (4) tick();

        // Address wrap from a high reset pc.
        sb1.push_back(32'hFFFF_FFF8);
        sb1.push_back(32'hFFFF_FFFC);
        for (int i = 0; i < 8; i++) sb1.push_back(32'(4 * i));
        reset1 = 1'b1;
        check("wrap_c0_raddr", mem_raddr1, 32'hFFFF_FFF8);
        repeat (6) tick();
        check("wrap_xfers", 32'(xfers1), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
